// File: rtl/ysyx_25040118_mem_responder.sv
// Load/store responder: one outstanding request, programmable latency, byte-lane word array.
// Optional MEM_RESPONDER_RAND_DELAY_EN randomises each latency in 1..LATENCY via an 8-bit LFSR.
module ysyx_25040118_mem_responder #(
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        wen_reg;
    logic [29:0] waddr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;

    logic                  accept;
    logic                  commit;
    logic [29:0]           word_off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]            cnt_load;
    logic                  unused_addr_bits;

    // Byte offset bits never select anything; words are addressed from addr[31:2].
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_ready = (state_reg == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign commit    = !rst && (state_reg == ST_WAIT) && (cnt_reg == 4'd0);

    // Word-granular unsigned difference: addresses below the base wrap high and fail the check.
    assign word_off = waddr_reg - MEM_BASE[31:2];
    assign in_range = (word_off[29:DEPTH_LOG2] == '0);
    assign idx      = word_off[DEPTH_LOG2-1:0];

`ifdef MEM_RESPONDER_RAND_DELAY_EN
    logic [7:0] lfsr_reg;
    logic [7:0] lfsr_next;

    assign lfsr_next = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);
    assign cnt_load  = 4'({28'd0, lfsr_reg[3:0]} % LATENCY);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= 8'hA5;
        end else if (accept) begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    assign cnt_load = 4'(LATENCY - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_reg   <= cnt_load;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        rsp_err_reg   <= !in_range;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Request fields only move on accept, so they stay put through WAIT and RESP.
    always_ff @(posedge clk) begin
        if (accept) begin
            wen_reg   <= req_wen;
            waddr_reg <= req_addr[31:2];
            wdata_reg <= req_wdata;
            wmask_reg <= req_wmask;
        end
    end

    // One byte-wide array per lane keeps the masked store a plain single-port write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (commit && in_range && wen_reg && wmask_reg[gi]) begin
                    lane_mem[idx] <= wdata_reg[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_byte_reg <= 8'h00;
                end else if (commit) begin
                    rd_byte_reg <= (in_range && !wen_reg) ? lane_mem[idx] : 8'h00;
                end
            end

            assign rsp_rdata[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_ysyx_25040118_mem_responder.sv
// Randomised bench for the mem responder against a word-array reference model.
module tb_ysyx_25040118_mem_responder;
`ifdef MEM_RESPONDER_RAND_DELAY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DLOG2 = 12;
    localparam logic [31:0] TOP   = BASE + 32'(4 * (2 ** DLOG2));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    ysyx_25040118_mem_responder #(
        .MEM_BASE  (BASE),
        .DEPTH_LOG2(DLOG2),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // One full request/response; hold>0 keeps rsp_ready low that many cycles in RESP.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int hold,
                       output logic [31:0] rdata, output logic err);
        int n;
        int lat;
        @(negedge clk);
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
        req_valid = 1'b1;
        rsp_ready = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
`ifdef MEM_RESPONDER_RAND_DELAY_EN
        check("latency_range", 32'(lat >= 1 && lat <= LAT), 32'd1);
`else
        check("latency", 32'(lat), 32'(LAT));
`endif
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, rdata);
            check("hold_err", 32'(rsp_err), 32'(err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_consumed", 32'(rsp_valid), 32'd0);
        check("err_cleared", 32'(rsp_err), 32'd0);
        check("back_idle", 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;
        $display("txn wen=%0d addr=%08h wdata=%08h mask=%h lat=%0d rdata=%08h err=%0d",
                 wen, addr, wdata, mask, lat, rdata, err);
    endtask

    logic [31:0] model [16];
    logic [31:0] rd;
    logic        er;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Directed word / byte / half accesses
        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, rd, er);
        check("sw_rdata_zero", rd, 32'd0);
        check("sw_err", 32'(er), 32'd0);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'b0000, 0, rd, er);
        check("lw_deadbeef", rd, 32'hDEAD_BEEF);
        check("lw_err", 32'(er), 32'd0);
        txn(1'b1, 32'h8000_0010, 32'h0000_00AA, 4'b0001, 0, rd, er);
        txn(1'b0, 32'h8000_0012, 32'h0, 4'b0000, 0, rd, er);
        check("lw_after_sb", rd, 32'hDEAD_BEAA);
        txn(1'b1, 32'h8000_0010, 32'h0000_1234, 4'b0011, 0, rd, er);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'b0000, 0, rd, er);
        check("lw_after_sh", rd, 32'hDEAD_1234);
        txn(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, rd, er);
        check("mask0_err", 32'(er), 32'd0);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'b0000, 5, rd, er);
        check("mask0_unchanged_hold", rd, 32'hDEAD_1234);

        // Range boundaries
        txn(1'b1, BASE, 32'h1111_2222, 4'b1111, 0, rd, er);
        txn(1'b1, TOP - 32'd4, 32'hCAFE_F00D, 4'b1111, 0, rd, er);
        check("top_sw_err", 32'(er), 32'd0);
        txn(1'b0, TOP - 32'd4, 32'h0, 4'b0000, 0, rd, er);
        check("top_lw", rd, 32'hCAFE_F00D);
        txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 0, rd, er);
        check("below_err", 32'(er), 32'd1);
        check("below_rdata", rd, 32'd0);
        txn(1'b0, TOP, 32'h0, 4'b0000, 0, rd, er);
        check("above_err", 32'(er), 32'd1);
        check("above_rdata", rd, 32'd0);
        txn(1'b1, TOP, 32'h5555_5555, 4'b1111, 0, rd, er);
        check("oor_sw_err", 32'(er), 32'd1);
        txn(1'b1, 32'h7FFF_FFFC, 32'h6666_6666, 4'b1111, 0, rd, er);
        txn(1'b0, BASE, 32'h0, 4'b0000, 0, rd, er);
        check("word0_unchanged", rd, 32'h1111_2222);
        txn(1'b0, TOP - 32'd4, 32'h0, 4'b0000, 0, rd, er);
        check("topword_unchanged", rd, 32'hCAFE_F00D);

        // Reset during WAIT drops the store
        txn(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'b1111, 0, rd, er);
        @(negedge clk);
        req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678; req_wmask = 4'b1111;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_wait_valid", 32'(rsp_valid), 32'd0);
        check("rst_wait_ready", 32'(req_ready), 32'd1);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h8000_0020, 32'h0, 4'b0000, 0, rd, er);
        check("rst_wait_old_value", rd, 32'h0BAD_F00D);

        // Randomised traffic over a 16-word window
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(1'b1, BASE + 32'h100 + 32'(4 * i), model[i], 4'b1111, 0, rd, er);
        end
        for (int i = 0; i < 200; i++) begin
            int          w;
            logic [31:0] d;
            logic [3:0]  m;
            logic [31:0] a;
            w = $urandom_range(0, 15);
            a = BASE + 32'h100 + 32'(4 * w) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 64))
                                                : TOP + 32'(4 * $urandom_range(0, 64));
                txn(1'b0, a, 32'h0, 4'b0000, 0, rd, er);
                check("rand_oor_err", 32'(er), 32'd1);
                check("rand_oor_rdata", rd, 32'd0);
            end else begin
                d = $urandom;
                m = 4'($urandom_range(0, 15));
                txn(1'b1, a, d, m, 0, rd, er);
                check("rand_sw_err", 32'(er), 32'd0);
                model[w] = merge(model[w], d, m);
                txn(1'b0, a, 32'h0, 4'b0000, 0, rd, er);
                check("rand_lw_data", rd, model[w]);
                check("rand_lw_err", 32'(er), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
